// File: rtl/dual_port_ram_if.sv
// Bus bundle for the simple dual-port RAM: one write port and one read port.
// The master drives both ports; the slave (the RAM) returns registered read data.
interface dual_port_ram_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic                  wr_enb;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_enb;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;

  modport master (
    output wr_enb,
    output wr_addr,
    output wr_data,
    output rd_enb,
    output rd_addr,
    input  rd_data
  );

  modport slave (
    input  wr_enb,
    input  wr_addr,
    input  wr_data,
    input  rd_enb,
    input  rd_addr,
    output rd_data
  );
endinterface

// File: rtl/dual_port_ram.sv
// Simple dual-port synchronous RAM with a registered read port and write-through
// bypass on same-address collisions. Synchronous active-low reset clears every word.
module dual_port_ram #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  dual_port_ram_if.slave    bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_reg;
  logic [DATA_WIDTH-1:0] rd_data_next;
  logic [DEPTH-1:0]      word_we;
  logic                  collision;

  // One-hot write decode; addresses outside an enabled write never select a word.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
      assign word_we[gi] = bus.wr_enb && (bus.wr_addr == ADDR_WIDTH'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!rst) begin
        mem_reg[i] <= '0;
      end else if (word_we[i]) begin
        mem_reg[i] <= bus.wr_data;
      end
    end
  end

  assign collision = bus.wr_enb && (bus.wr_addr == bus.rd_addr);

  // A same-address write wins over the stored word so the reader sees new data.
  always_comb begin
    rd_data_next = rd_data_reg;
    if (bus.rd_enb) begin
      rd_data_next = collision ? bus.wr_data : mem_reg[bus.rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_data_reg <= '0;
    end else begin
      rd_data_reg <= rd_data_next;
    end
  end

  assign bus.rd_data = rd_data_reg;
endmodule

// File: tb/tb_dual_port_ram.sv
// Directed bench for dual_port_ram: reset clear, write/read back, collisions,
// read-data hold and mid-operation reset, with hand-computed expectations.
module tb_dual_port_ram;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  dual_port_ram_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) bus ();

  dual_port_ram #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
    $display("check %-14s observed 0x%02h expected 0x%02h", tag, obs, exp);
  endtask

  task automatic do_write(input logic [3:0] addr, input logic [7:0] data);
    bus.wr_enb  = 1'b1;
    bus.wr_addr = addr;
    bus.wr_data = data;
    bus.rd_enb  = 1'b0;
    tick();
    bus.wr_enb  = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] addr);
    bus.wr_enb  = 1'b0;
    bus.rd_enb  = 1'b1;
    bus.rd_addr = addr;
    tick();
    bus.rd_enb  = 1'b0;
  endtask

  initial begin
    rst         = 1'b0;
    bus.wr_enb  = 1'b1;
    bus.wr_addr = 4'd4;
    bus.wr_data = 8'hEE;
    bus.rd_enb  = 1'b0;
    bus.rd_addr = 4'd0;

    // Reset held 2 clocks with a write pending; the write must be ignored.
    tick();
    tick();
    check("reset_rd_data", bus.rd_data, 8'h00);
    rst        = 1'b1;
    bus.wr_enb = 1'b0;
    for (int a = 0; a < 16; a++) begin
      do_read(4'(a));
      check("reset_clear", bus.rd_data, 8'h00);
    end

    // Write then read back with one-clock latency.
    do_write(4'd3, 8'hA5);
    do_write(4'd15, 8'h3C);
    do_read(4'd3);
    check("readback_3", bus.rd_data, 8'hA5);
    do_read(4'd15);
    check("readback_15", bus.rd_data, 8'h3C);

    // Same-address collision: write-through.
    do_write(4'd7, 8'h11);
    bus.wr_enb  = 1'b1;
    bus.wr_addr = 4'd7;
    bus.wr_data = 8'h99;
    bus.rd_enb  = 1'b1;
    bus.rd_addr = 4'd7;
    tick();
    bus.wr_enb  = 1'b0;
    bus.rd_enb  = 1'b0;
    check("collide_bypass", bus.rd_data, 8'h99);
    do_read(4'd7);
    check("collide_mem", bus.rd_data, 8'h99);

    // Different addresses in the same cycle are independent.
    do_write(4'd2, 8'h55);
    bus.wr_enb  = 1'b1;
    bus.wr_addr = 4'd9;
    bus.wr_data = 8'h77;
    bus.rd_enb  = 1'b1;
    bus.rd_addr = 4'd2;
    tick();
    bus.wr_enb  = 1'b0;
    bus.rd_enb  = 1'b0;
    check("indep_read", bus.rd_data, 8'h55);
    do_read(4'd9);
    check("indep_write", bus.rd_data, 8'h77);

    // rd_data holds while rd_enb is low, even as the word underneath changes.
    do_read(4'd3);
    check("hold_start", bus.rd_data, 8'hA5);
    for (int c = 0; c < 3; c++) begin
      bus.rd_addr = 4'd15;
      do_write(4'd3, 8'h00);
      check("hold", bus.rd_data, 8'hA5);
    end
    do_read(4'd3);
    check("hold_release", bus.rd_data, 8'h00);

    // Fill memory, then reset during a write of 0x12 at address 5.
    for (int a = 0; a < 16; a++) begin
      do_write(4'(a), 8'hFF);
    end
    do_read(4'd5);
    check("fill_ff", bus.rd_data, 8'hFF);
    rst         = 1'b0;
    bus.wr_enb  = 1'b1;
    bus.wr_addr = 4'd5;
    bus.wr_data = 8'h12;
    bus.rd_enb  = 1'b1;
    bus.rd_addr = 4'd5;
    tick();
    check("midrst_rd_data", bus.rd_data, 8'h00);
    rst        = 1'b1;
    bus.wr_enb = 1'b0;
    bus.rd_enb = 1'b0;
    for (int a = 0; a < 16; a++) begin
      do_read(4'(a));
      check("midrst_clear", bus.rd_data, 8'h00);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
